mod_sampler: RTL and testbench
==============================

MOD_SAMPLER -- requirements
Module: mod_sampler

Interface
REQ-001 The block SHALL have one parameter: CYCLE_W, default 15, width of CYCLE_0/CYCLE_1 and IDX.
REQ-002 CLK  in  1  sole clock; all logic on its rising edge.
REQ-003 RESETN  in  1  reset, synchronous and active-low.
REQ-004 UPDATE_SETTINGS  in  1  one-cycle pulse; settings inputs are valid in this cycle.
REQ-005 REQ_RD_SEGMENT  in  1  requested read segment (0/1).
REQ-006 CYCLE_0, CYCLE_1  in  CYCLE_W each  last sample index of segment 0/1 (sample count minus 1).
REQ-007 FREQ_DIV_0, FREQ_DIV_1  in  32 each  clocks per sample for segment 0/1.
REQ-008 REP  in  32  loop count for the requested segment; 0xFFFFFFFF = infinite.
REQ-009 IDX  out  CYCLE_W  current sample index.
REQ-010 SEGMENT  out  1  segment currently being read.
REQ-011 IDX_VALID  out  1  one-cycle pulse whenever IDX or SEGMENT changes.
REQ-012 STOP  out  1  high when a finite repetition has completed; IDX frozen.

Function
REQ-013 On UPDATE_SETTINGS the block SHALL latch all setting inputs, visible to the counters from the next cycle (latency 1).
REQ-014 Effective divider = max(FREQ_DIV_n, 1); FREQ_DIV_n = 0 behaves as 1 (advance every clock).
REQ-015 Divider counter: counts 0..div-1 on the active segment; at div-1 it SHALL return to 0 and advance IDX.
REQ-016 IDX advance: IDX < CYCLE_n -> IDX+1; IDX >= CYCLE_n -> wrap to 0 (end-of-loop event).
REQ-017 State machine SHALL have states RUN, PENDING, FINITE, STOPPED.
REQ-018 RUN: active segment loops forever; UPDATE with REQ_RD_SEGMENT != SEGMENT -> PENDING.
REQ-019 PENDING: at next end-of-loop event, SEGMENT SHALL toggle, IDX = 0, divider = 0, loop counter = 0; then go to RUN if latched REP = 0xFFFFFFFF, else FINITE.
REQ-020 FINITE: each end-of-loop increments the 32-bit loop counter; when the counter equals REP at an end-of-loop, go to STOPPED with IDX held at CYCLE_n (no wrap), so the segment plays REP+1 times.
REQ-021 STOPPED: STOP = 1, IDX and SEGMENT frozen, divider halted; UPDATE -> evaluated as from RUN (segment change -> PENDING, which switches immediately since no loop is running; same segment -> RUN or FINITE per REP, IDX = 0).
REQ-022 UPDATE with REQ_RD_SEGMENT = SEGMENT in RUN/FINITE SHALL NOT restart IDX; new CYCLE/FREQ_DIV apply from next cycle; loop counter cleared; state = RUN if REP infinite else FINITE.
REQ-023 If the new CYCLE_n < current IDX, the next advance SHALL wrap IDX to 0 (REQ-016), counting as end-of-loop.
REQ-024 UPDATE arriving in the same cycle as an end-of-loop event: the end-of-loop SHALL be processed with the old settings; the update applies from the next cycle.
REQ-025 A second UPDATE while PENDING SHALL replace latched settings; if it requests the current SEGMENT, the switch is cancelled (-> RUN/FINITE per REQ-022).
REQ-026 IDX_VALID SHALL be asserted in the cycle following any change of IDX or SEGMENT and never otherwise.
REQ-027 STOP SHALL be registered; it deasserts in the cycle after the UPDATE that leaves STOPPED.

Reset
REQ-028 With RESETN = 0 at a clock edge: IDX = 0, SEGMENT = 0, STOP = 0, IDX_VALID = 0, state RUN, divider = 0, loop counter = 0, latched CYCLE_0/1 = 0, FREQ_DIV_0/1 = 0, REP = 0xFFFFFFFF, REQ_RD_SEGMENT = 0.
REQ-029 Reset mid-operation (any state, incl. PENDING) SHALL discard pending switches and latched settings in the same edge; UPDATE_SETTINGS concurrent with reset is ignored.

Verification
REQ-030 Reset, UPDATE seg 0, CYCLE_0 = 3, FREQ_DIV_0 = 2, REP infinite -> IDX 0,0,1,1,2,2,3,3,0... ; IDX_VALID every 2nd clock.
REQ-031 Running seg 0 (CYCLE_0 = 3, div 1) at IDX = 1, UPDATE seg 1, CYCLE_1 = 1, REP = 1 -> IDX 2,3 on seg 0, then seg 1 IDX 0,1,0,1, then STOP = 1 with IDX = 1 frozen.
REQ-032 FREQ_DIV_0 = 0, CYCLE_0 = 2 -> IDX advances every clock 0,1,2,0.
REQ-033 IDX = 10 on seg 0, UPDATE same seg with CYCLE_0 = 4 -> next advance IDX = 0, no segment change.
REQ-034 In STOPPED, UPDATE seg 0 (other segment) REP = 0 -> SEGMENT = 0, IDX = 0 on next cycle; STOP = 0; after one loop STOP = 1.
REQ-035 RESETN low for one cycle while PENDING -> all outputs at reset values, no segment switch afterwards.

Source files
------------

// File: rtl/mod_sampler.sv
// mod_sampler: two-segment sample index generator.
// Each segment is a loop of CYCLE_n+1 samples, each sample held for
// max(FREQ_DIV_n,1) clocks. A segment switch waits for the end of the
// current loop. A finite repeat count stops the loop on its last sample.
//
// Handshake: IDX_VALID is a one-cycle strobe. It is high in exactly the
// cycles where IDX or SEGMENT holds a value different from the previous
// cycle. There is no back-pressure: a consumer that is not ready simply
// misses that strobe.
//
// When UPDATE_SETTINGS coincides with a divider tick, the tick (index
// advance or wrap) is taken with the settings that were latched before
// it. The state decision on that edge comes from the update itself.
module mod_sampler #(
   parameter int CYCLE_W = 15
) (
   input  logic               CLK,
   input  logic               RESETN,
   input  logic               UPDATE_SETTINGS,
   input  logic               REQ_RD_SEGMENT,
   input  logic [CYCLE_W-1:0] CYCLE_0,
   input  logic [CYCLE_W-1:0] CYCLE_1,
   input  logic [31:0]        FREQ_DIV_0,
   input  logic [31:0]        FREQ_DIV_1,
   input  logic [31:0]        REP,
   output logic [CYCLE_W-1:0] IDX,
   output logic               SEGMENT,
   output logic               IDX_VALID,
   output logic               STOP,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PENDING = 2'd1,
      ST_FINITE  = 2'd2,
      ST_STOPPED = 2'd3
   } state_t;

   localparam logic [31:0] REP_INF = 32'hFFFF_FFFF;

   state_t             state;
   state_t             state_n;

   // latched settings
   logic [CYCLE_W-1:0] cyc0_q;
   logic [CYCLE_W-1:0] cyc1_q;
   logic [31:0]        div0_q;
   logic [31:0]        div1_q;
   logic [31:0]        rep_q;
   logic               req_seg_q;

   // counters
   logic [31:0]        div_cnt;
   logic [31:0]        loop_cnt;

   // next values
   logic [CYCLE_W-1:0] idx_n;
   logic               seg_n;
   logic [31:0]        div_n;
   logic [31:0]        loop_n;
   logic               stop_n;

   // per-cycle decode
   logic [CYCLE_W-1:0] cyc_act;
   logic [31:0]        div_act;
   logic [31:0]        div_last;
   logic               running;
   logic               tick;
   logic               wrap;
   logic               eol;
   logic               rep_inf_in;
   logic               rep_inf_q;

   assign dbg_state = state;

   // Select the active segment's settings and decode divider tick / end-of-loop.
   always_comb begin
      cyc_act    = SEGMENT ? cyc1_q : cyc0_q;
      div_act    = SEGMENT ? div1_q : div0_q;
      // A divider of 0 behaves as 1, so the last count is 0 in both cases.
      div_last   = (div_act == 32'd0) ? 32'd0 : div_act - 32'd1;
      running    = (state != ST_STOPPED);
      // ">=" rather than "==" so that shrinking the divider mid-sample
      // ends the sample at once instead of letting the count run away.
      tick       = running && (div_cnt >= div_last);
      wrap       = (IDX >= cyc_act);
      eol        = tick && wrap;
      rep_inf_in = (REP == REP_INF);
      rep_inf_q  = (rep_q == REP_INF);
   end

   // Next-state logic: counter stepping first, then the update / end-of-loop decision.
   always_comb begin
      state_n = state;
      idx_n   = IDX;
      seg_n   = SEGMENT;
      div_n   = div_cnt;
      loop_n  = loop_cnt;
      stop_n  = STOP;

      if (running) begin
         if (tick) begin
            div_n = 32'd0;
            idx_n = wrap ? '0 : IDX + CYCLE_W'(1);
         end else begin
            div_n = div_cnt + 32'd1;
         end
      end

      if (UPDATE_SETTINGS) begin
         loop_n = 32'd0;
         if (state == ST_STOPPED) begin
            // Nothing is playing, so a segment change takes effect at once.
            stop_n  = 1'b0;
            idx_n   = '0;
            div_n   = 32'd0;
            seg_n   = REQ_RD_SEGMENT;
            state_n = rep_inf_in ? ST_RUN : ST_FINITE;
         end else if (REQ_RD_SEGMENT != SEGMENT) begin
            state_n = ST_PENDING;
         end else begin
            // Same segment: keep playing from the current index.
            state_n = rep_inf_in ? ST_RUN : ST_FINITE;
         end
      end else if (eol) begin
         case (state)
            ST_PENDING: begin
               seg_n   = req_seg_q;
               idx_n   = '0;
               div_n   = 32'd0;
               loop_n  = 32'd0;
               state_n = rep_inf_q ? ST_RUN : ST_FINITE;
            end
            ST_FINITE: begin
               if (loop_cnt == rep_q) begin
                  // Last loop done: park on the final sample.
                  state_n = ST_STOPPED;
                  stop_n  = 1'b1;
                  idx_n   = cyc_act;
               end else begin
                  loop_n = loop_cnt + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Register state, counters, outputs and latched settings.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state     <= ST_RUN;
         IDX       <= '0;
         SEGMENT   <= 1'b0;
         STOP      <= 1'b0;
         IDX_VALID <= 1'b0;
         div_cnt   <= 32'd0;
         loop_cnt  <= 32'd0;
         cyc0_q    <= '0;
         cyc1_q    <= '0;
         div0_q    <= 32'd0;
         div1_q    <= 32'd0;
         rep_q     <= REP_INF;
         req_seg_q <= 1'b0;
      end else begin
         state     <= state_n;
         IDX       <= idx_n;
         SEGMENT   <= seg_n;
         STOP      <= stop_n;
         IDX_VALID <= (idx_n != IDX) || (seg_n != SEGMENT);
         div_cnt   <= div_n;
         loop_cnt  <= loop_n;
         if (UPDATE_SETTINGS) begin
            cyc0_q    <= CYCLE_0;
            cyc1_q    <= CYCLE_1;
            div0_q    <= FREQ_DIV_0;
            div1_q    <= FREQ_DIV_1;
            rep_q     <= REP;
            req_seg_q <= REQ_RD_SEGMENT;
         end
      end
   end

endmodule

// File: tb/tb_mod_sampler.sv
// Bench for mod_sampler: directed scenarios followed by random updates and
// resets. A reference model predicts every output event (index or segment
// change, STOP change). The model works in terms of "clocks spent on the
// current sample" and "plays left". A forked monitor matches the DUT's
// events against the expected queue by cycle stamp.
module tb_mod_sampler;

   localparam int CW = 15;
   localparam int W  = 32 + 3 + CW;

   logic          CLK;
   logic          RESETN;
   logic          UPDATE_SETTINGS;
   logic          REQ_RD_SEGMENT;
   logic [CW-1:0] CYCLE_0;
   logic [CW-1:0] CYCLE_1;
   logic [31:0]   FREQ_DIV_0;
   logic [31:0]   FREQ_DIV_1;
   logic [31:0]   REP;
   logic [CW-1:0] IDX;
   logic          SEGMENT;
   logic          IDX_VALID;
   logic          STOP;
   logic [1:0]    dbg_state;

   mod_sampler #(.CYCLE_W(CW)) dut (
      .CLK             (CLK),
      .RESETN          (RESETN),
      .UPDATE_SETTINGS (UPDATE_SETTINGS),
      .REQ_RD_SEGMENT  (REQ_RD_SEGMENT),
      .CYCLE_0         (CYCLE_0),
      .CYCLE_1         (CYCLE_1),
      .FREQ_DIV_0      (FREQ_DIV_0),
      .FREQ_DIV_1      (FREQ_DIV_1),
      .REP             (REP),
      .IDX             (IDX),
      .SEGMENT         (SEGMENT),
      .IDX_VALID       (IDX_VALID),
      .STOP            (STOP),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [31:0] cyc_cnt;
   initial cyc_cnt = 32'd0;
   always @(posedge CLK) cyc_cnt <= cyc_cnt + 32'd1;

   // ---------------- scoreboard ----------------
   // Entry layout: {stamp[31:0], idx_valid, stop, segment, idx[CW-1:0]}
   logic [W-1:0] exp_q[$];
   int n_checks;
   int n_pass;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc_cnt);
   endtask

   // ---------------- reference model ----------------
   int          m_idx;
   bit          m_seg;
   bit          m_stop;
   bit          m_pend;
   bit          m_req;
   longint      m_phase;   // clocks already spent on the current sample
   longint      m_plays;   // further loops after the current one; -1 = forever
   longint      m_cyc[2];
   longint      m_div[2];
   logic [31:0] m_rep;

   function automatic longint plays_for(input logic [31:0] r);
      return (r == 32'hFFFF_FFFF) ? -1 : longint'(r);
   endfunction

   task automatic model_step(input bit upd, input bit req, input logic [CW-1:0] c0,
                             input logic [CW-1:0] c1, input logic [31:0] d0,
                             input logic [31:0] d1, input logic [31:0] rep, input bit rstn);
      int          o_idx;
      bit          o_seg;
      bit          o_stop;
      bit          vld;
      bit          eol;
      longint      eff;
      longint      cyc;
      logic [CW-1:0] idx_bits;
      logic [31:0] stamp;
      o_idx  = m_idx;
      o_seg  = m_seg;
      o_stop = m_stop;
      vld    = 1'b0;
      eol    = 1'b0;
      if (!rstn) begin
         m_idx = 0; m_seg = 0; m_stop = 0; m_pend = 0; m_req = 0;
         m_phase = 0; m_plays = -1;
         m_cyc[0] = 0; m_cyc[1] = 0; m_div[0] = 0; m_div[1] = 0;
         m_rep = 32'hFFFF_FFFF;
      end else begin
         cyc = m_cyc[m_seg];
         eff = (m_div[m_seg] == 0) ? 1 : m_div[m_seg];
         if (!m_stop) begin
            if (m_phase + 1 >= eff) begin
               m_phase = 0;
               if (m_idx >= cyc) begin
                  eol   = 1'b1;
                  m_idx = 0;
               end else begin
                  m_idx = m_idx + 1;
               end
            end else begin
               m_phase = m_phase + 1;
            end
         end
         if (upd) begin
            if (m_stop) begin
               m_stop = 0; m_idx = 0; m_phase = 0; m_seg = req; m_pend = 0;
               m_plays = plays_for(rep);
            end else if (req != m_seg) begin
               m_pend = 1;
            end else begin
               m_pend  = 0;
               m_plays = plays_for(rep);
            end
            m_req = req;
            m_cyc[0] = c0; m_cyc[1] = c1; m_div[0] = d0; m_div[1] = d1;
            m_rep = rep;
         end else if (eol) begin
            if (m_pend) begin
               m_pend = 0; m_seg = m_req; m_idx = 0; m_phase = 0;
               m_plays = plays_for(m_rep);
            end else if (m_plays == 0) begin
               m_stop = 1;
               m_idx  = int'(cyc);
            end else if (m_plays > 0) begin
               m_plays = m_plays - 1;
            end
         end
         vld = (m_idx != o_idx) || (m_seg != o_seg);
      end
      if (vld || (m_stop != o_stop)) begin
         idx_bits = m_idx[CW-1:0];
         stamp    = cyc_cnt + 32'd1;
         exp_q.push_back({stamp, vld, m_stop, m_seg, idx_bits});
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input bit upd, input bit req, input logic [CW-1:0] c0,
                       input logic [CW-1:0] c1, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] rep, input bit rstn);
      @(negedge CLK);
      UPDATE_SETTINGS = upd;
      REQ_RD_SEGMENT  = req;
      CYCLE_0         = c0;
      CYCLE_1         = c1;
      FREQ_DIV_0      = d0;
      FREQ_DIV_1      = d1;
      REP             = rep;
      RESETN          = rstn;
      model_step(upd, req, c0, c1, d0, d1, rep, rstn);
   endtask

   // Idle cycle: settings inputs carry noise that must be ignored.
   task automatic idle();
      tick(1'b0, 1'($urandom_range(0, 1)), CW'($urandom_range(0, 31)), CW'($urandom_range(0, 31)),
           32'($urandom), 32'($urandom), 32'($urandom), 1'b1);
   endtask

   task automatic upd(input bit req, input int c0, input int c1, input int d0, input int d1,
                      input logic [31:0] rep);
      tick(1'b1, req, CW'(c0), CW'(c1), 32'(d0), 32'(d1), rep, 1'b1);
   endtask

   task automatic settle();
      @(posedge CLK);
      #2;
   endtask

   // Run idle cycles until the model says IDX will equal target, then confirm on the DUT.
   task automatic wait_idx(input string name, input int target);
      for (int i = 0; i < 200 && m_idx != target; i++) idle();
      settle();
      check(name, 64'(IDX), 64'(target));
   endtask

   // ---------------- monitor ----------------
   task automatic monitor();
      logic         prev_stop;
      logic [W-1:0] item;
      logic [W-1:0] got;
      prev_stop = 1'b0;
      forever begin
         @(posedge CLK);
         #2;
         got = {cyc_cnt, IDX_VALID, STOP, SEGMENT, IDX};
         // Anything still queued from an earlier cycle was an event the DUT never showed.
         while (exp_q.size() > 0 && exp_q[0][W-1 -: 32] < cyc_cnt) begin
            item = exp_q.pop_front();
            check("sb_missed_event", 64'(got), 64'(item));
         end
         if (IDX_VALID === 1'b1 || STOP !== prev_stop) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_event", 64'(got), 64'(0));
            end else begin
               item = exp_q.pop_front();
               check("sb_event", 64'(got), 64'(item));
            end
         end
         prev_stop = STOP;
      end
   endtask

   // ---------------- stimulus ----------------
   int exp_seq[9];
   int r;
   int rsel;
   logic [31:0] rrep;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      exp_seq  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      UPDATE_SETTINGS = 1'b0;
      REQ_RD_SEGMENT  = 1'b0;
      CYCLE_0 = '0; CYCLE_1 = '0;
      FREQ_DIV_0 = '0; FREQ_DIV_1 = '0; REP = '0;
      RESETN = 1'b0;
      m_stop = 1'b0; m_idx = 0; m_seg = 0;

      // Reset with a concurrent update that must be ignored.
      tick(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
      tick(1'b1, 1'b1, CW'(5), CW'(5), 32'd3, 32'd3, 32'd1, 1'b0);
      tick(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
      settle();
      check("reset_idx", 64'(IDX), 64'(0));
      check("reset_seg", 64'(SEGMENT), 64'(0));
      check("reset_stop", 64'(STOP), 64'(0));
      check("reset_valid", 64'(IDX_VALID), 64'(0));
      check("reset_state", 64'(dbg_state), 64'(0));

      fork
         monitor();
      join_none

      // Segment 0, 4 samples, 2 clocks each, forever.
      upd(1'b0, 3, 0, 2, 0, 32'hFFFF_FFFF);
      settle();
      check("div2_seq0", 64'(IDX), 64'(exp_seq[0]));
      for (int k = 1; k < 9; k++) begin
         idle();
         settle();
         check($sformatf("div2_seq%0d", k), 64'(IDX), 64'(exp_seq[k]));
      end

      // Divider 1 on segment 0, then request segment 1 with two plays.
      upd(1'b0, 3, 1, 1, 1, 32'hFFFF_FFFF);
      wait_idx("wait_idx1", 1);
      upd(1'b1, 3, 1, 1, 1, 32'd1);
      for (int k = 0; k < 12; k++) idle();
      settle();
      check("switch_stop", 64'(STOP), 64'(1));
      check("switch_seg", 64'(SEGMENT), 64'(1));
      check("switch_idx_frozen", 64'(IDX), 64'(1));
      check("switch_state", 64'(dbg_state), 64'(3));

      // From STOPPED, back to segment 0 with a single play.
      upd(1'b0, 3, 1, 1, 1, 32'd0);
      settle();
      check("restart_stop", 64'(STOP), 64'(0));
      check("restart_seg", 64'(SEGMENT), 64'(0));
      check("restart_idx", 64'(IDX), 64'(0));
      for (int k = 0; k < 8; k++) idle();
      settle();
      check("oneplay_stop", 64'(STOP), 64'(1));
      check("oneplay_idx", 64'(IDX), 64'(3));

      // Divider 0 acts as 1.
      upd(1'b0, 2, 1, 0, 1, 32'hFFFF_FFFF);
      for (int k = 0; k < 7; k++) idle();

      // Shrinking CYCLE below the current index wraps at the next advance.
      upd(1'b0, 15, 1, 3, 1, 32'hFFFF_FFFF);
      wait_idx("wait_idx10", 10);
      upd(1'b0, 4, 1, 3, 1, 32'hFFFF_FFFF);
      idle();
      idle();
      settle();
      check("shrink_idx", 64'(IDX), 64'(0));
      check("shrink_seg", 64'(SEGMENT), 64'(0));

      // Reset while a switch is pending discards it.
      upd(1'b0, 7, 2, 3, 1, 32'hFFFF_FFFF);
      idle();
      upd(1'b1, 7, 2, 3, 1, 32'hFFFF_FFFF);
      idle();
      tick(1'b1, 1'b1, CW'(7), CW'(2), 32'd1, 32'd1, 32'hFFFF_FFFF, 1'b0);
      settle();
      check("pend_rst_idx", 64'(IDX), 64'(0));
      check("pend_rst_seg", 64'(SEGMENT), 64'(0));
      check("pend_rst_valid", 64'(IDX_VALID), 64'(0));
      check("pend_rst_stop", 64'(STOP), 64'(0));
      for (int k = 0; k < 30; k++) idle();
      settle();
      check("pend_rst_noswitch", 64'(SEGMENT), 64'(0));

      // Random updates and occasional resets.
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 299));
         if (r == 0) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), CW'($urandom_range(0, 7)),
                 CW'($urandom_range(0, 7)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                 32'($urandom), 1'b0);
         end else if (r < 11) begin
            rsel = int'($urandom_range(0, 4));
            case (rsel)
               0:       rrep = 32'hFFFF_FFFF;
               1:       rrep = 32'd0;
               2:       rrep = 32'd1;
               3:       rrep = 32'd2;
               default: rrep = 32'($urandom_range(0, 5));
            endcase
            upd(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rrep);
         end else begin
            idle();
         end
      end

      for (int k = 0; k < 5; k++) idle();
      @(posedge CLK);
      #4;
      check("sb_drain", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
